// File: rtl/reg_writeback_queue.sv
// Register writeback queue: FIFO of pending {reg, data} writes with read-port forwarding.
// Latency: one cycle from enqueue to reg_write; rf_stall holds the head, and wb_ready drops only when full.
module reg_writeback_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_valid,
    input  logic [4:0]       wb_reg,
    input  logic [WIDTH-1:0] wb_data,
    output logic             wb_ready,
    input  logic             rf_stall,
    output logic             reg_write,
    output logic [4:0]       write_reg,
    output logic [WIDTH-1:0] write_data,
    input  logic [4:0]       fwd_reg1,
    input  logic [4:0]       fwd_reg2,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [WIDTH-1:0] fwd_data1,
    output logic [WIDTH-1:0] fwd_data2,
    output logic             empty,
    output logic             dropped
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [4:0] XZR = 5'd31;

    typedef struct packed {
        logic [4:0]       rg;
        logic [WIDTH-1:0] dat;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_dropped;

    logic          w_empty;
    logic          w_accept;
    logic          w_enq;
    logic          w_deq;
    logic [PW-1:0] w_idx;
    entry_t        w_head_ent;

    assign w_empty    = (r_count == '0);
    assign wb_ready   = (r_count < CW'(DEPTH));
    assign w_accept   = wb_valid && wb_ready;
    assign w_enq      = w_accept && (wb_reg != XZR);
    // The memory commits on the same edge, so no strobe may leave while reset is asserted.
    assign w_deq      = !w_empty && !rf_stall && !reset;
    assign w_head_ent = r_mem[r_head];

    assign reg_write  = w_deq;
    assign write_reg  = w_empty ? '0 : w_head_ent.rg;
    assign write_data = w_empty ? '0 : w_head_ent.dat;
    assign empty      = w_empty;
    assign dropped    = r_dropped;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_dropped <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            r_count   <= r_count + CW'(w_enq) - CW'(w_deq);
            r_dropped <= w_accept && (wb_reg == XZR);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_enq) begin
            r_mem[r_tail] <= '{rg: wb_reg, dat: wb_data};
        end
    end

    // Walk oldest to youngest so the last match wins; the head still counts while being written.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        w_idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (CW'(i) < r_count) begin
                if ((r_mem[w_idx].rg == fwd_reg1) && (fwd_reg1 != XZR)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = r_mem[w_idx].dat;
                end
                if ((r_mem[w_idx].rg == fwd_reg2) && (fwd_reg2 != XZR)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = r_mem[w_idx].dat;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: directed vector table, reset sequence, and random traffic against a queue model.
module tb_reg_writeback_queue;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset, wb_valid, rf_stall;
    logic [4:0]       wb_reg, fwd_reg1, fwd_reg2;
    logic [WIDTH-1:0] wb_data;
    logic             wb_ready, reg_write, fwd_hit1, fwd_hit2, empty, dropped;
    logic [4:0]       write_reg;
    logic [WIDTH-1:0] write_data, fwd_data1, fwd_data2;

    always #5 clk = ~clk;

    reg_writeback_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .wb_ready(wb_ready), .rf_stall(rf_stall), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1),
        .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .empty(empty),
        .dropped(dropped)
    );

    typedef struct {
        logic rst; logic v; logic [4:0] rg; logic [63:0] d; logic st; logic [4:0] f1; logic [4:0] f2;
    } in_t;
    typedef struct {
        logic [4:0] rg; logic [63:0] d;
    } ent_t;
    typedef struct {
        in_t x; logic rdy; logic emp; logic rw; logic [4:0] wreg; logic [63:0] wd;
        logic h1; logic [63:0] fd1; logic h2; logic [63:0] fd2; logic drop;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    ent_t q[$];
    logic m_drop = 1'b0;
    in_t  cur;
    vec_t tbl[$];

    function automatic in_t mk(input logic rst, input logic v, input logic [4:0] rg, input logic [63:0] d,
                               input logic st, input logic [4:0] f1, input logic [4:0] f2);
        in_t x;
        x.rst = rst; x.v = v; x.rg = rg; x.d = d; x.st = st; x.f1 = f1; x.f2 = f2;
        return x;
    endfunction

    function automatic vec_t V(input in_t x, input logic rdy, input logic emp, input logic rw,
                               input logic [4:0] wreg, input logic [63:0] wd, input logic h1,
                               input logic [63:0] fd1, input logic h2, input logic [63:0] fd2,
                               input logic drop);
        vec_t t;
        t.x = x; t.rdy = rdy; t.emp = emp; t.rw = rw; t.wreg = wreg; t.wd = wd;
        t.h1 = h1; t.fd1 = fd1; t.h2 = h2; t.fd2 = fd2; t.drop = drop;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: pending writes are a plain queue; forwarding scans it youngest-first.
    task automatic model_check();
        logic        m_emp, m_h1, m_h2;
        logic [63:0] m_fd1, m_fd2;
        m_emp = (q.size() == 0);
        m_h1 = 1'b0; m_h2 = 1'b0; m_fd1 = '0; m_fd2 = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!m_h1 && cur.f1 != 5'd31 && q[i].rg == cur.f1) begin m_h1 = 1'b1; m_fd1 = q[i].d; end
            if (!m_h2 && cur.f2 != 5'd31 && q[i].rg == cur.f2) begin m_h2 = 1'b1; m_fd2 = q[i].d; end
        end
        chk("m_ready", 64'(wb_ready), 64'(q.size() < DEPTH));
        chk("m_empty", 64'(empty), 64'(m_emp));
        chk("m_reg_write", 64'(reg_write), 64'(!m_emp && !cur.st && !cur.rst));
        chk("m_write_reg", 64'(write_reg), m_emp ? 64'd0 : 64'(q[0].rg));
        chk("m_write_data", write_data, m_emp ? 64'd0 : q[0].d);
        chk("m_hit1", 64'(fwd_hit1), 64'(m_h1));
        chk("m_data1", fwd_data1, m_fd1);
        chk("m_hit2", 64'(fwd_hit2), 64'(m_h2));
        chk("m_data2", fwd_data2, m_fd2);
        chk("m_dropped", 64'(dropped), 64'(m_drop));
    endtask

    task automatic drive(input in_t x, input bit do_chk);
        @(negedge clk);
        cur = x;
        reset = x.rst; wb_valid = x.v; wb_reg = x.rg; wb_data = x.d;
        rf_stall = x.st; fwd_reg1 = x.f1; fwd_reg2 = x.f2;
        #1;
        if (do_chk) model_check();
    endtask

    task automatic clock_edge();
        bit acc;
        @(posedge clk);
        if (cur.rst) begin
            q.delete();
            m_drop = 1'b0;
        end else begin
            acc = cur.v && (q.size() < DEPTH);
            if (q.size() > 0 && !cur.st) void'(q.pop_front());
            if (acc && cur.rg != 5'd31) q.push_back('{rg: cur.rg, d: cur.d});
            m_drop = acc && (cur.rg == 5'd31);
        end
    endtask

    initial begin
        in_t x;
        // single write
        tbl.push_back(V(mk(0,1,11,100,0,0,0), 1,1,0, 0,0,  0,0,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,0,0),    1,0,1, 11,100,0,0,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,0,0),    1,1,0, 0,0,  0,0,0,0, 0));
        // fill under stall, then drain
        tbl.push_back(V(mk(0,1,1,10,1,0,0),   1,1,0, 0,0,  0,0,0,0, 0));
        tbl.push_back(V(mk(0,1,2,20,1,0,0),   1,0,0, 1,10, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,1,3,30,1,0,0),   1,0,0, 1,10, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,1,4,40,1,0,0),   1,0,0, 1,10, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,1,5,50,1,0,0),   0,0,0, 1,10, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,1,5,50,0,0,0),   0,0,1, 1,10, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,1,5,50,0,0,0),   1,0,1, 2,20, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,0,0),    1,0,1, 3,30, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,0,0),    1,0,1, 4,40, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,0,0),    1,0,1, 5,50, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,0,0),    1,1,0, 0,0,  0,0,0,0, 0));
        // forwarding of the younger duplicate
        tbl.push_back(V(mk(0,1,7,5,1,7,8),    1,1,0, 0,0,  0,0,0,0, 0));
        tbl.push_back(V(mk(0,1,7,9,1,7,8),    1,0,0, 7,5,  1,5,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,1,7,8),    1,0,0, 7,5,  1,9,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,7,8),    1,0,1, 7,5,  1,9,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,7,8),    1,0,1, 7,9,  1,9,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,7,8),    1,1,0, 0,0,  0,0,0,0, 0));
        // zero register is discarded
        tbl.push_back(V(mk(0,1,31,123456789,0,31,0), 1,1,0, 0,0, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,31,0),   1,1,0, 0,0,  0,0,0,0, 1));
        tbl.push_back(V(mk(0,0,0,0,0,31,0),   1,1,0, 0,0,  0,0,0,0, 0));
        // accept and dequeue on the same edge
        tbl.push_back(V(mk(0,1,9,1,0,0,0),    1,1,0, 0,0,  0,0,0,0, 0));
        tbl.push_back(V(mk(0,1,3,77,0,0,0),   1,0,1, 9,1,  0,0,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,0,0),    1,0,1, 3,77, 0,0,0,0, 0));
        tbl.push_back(V(mk(0,0,0,0,0,0,0),    1,1,0, 0,0,  0,0,0,0, 0));

        drive(mk(1,1,4,64'hdead,0,0,0), 1'b0); clock_edge();
        drive(mk(1,0,0,0,0,0,0), 1'b1);        clock_edge();

        foreach (tbl[k]) begin
            drive(tbl[k].x, 1'b1);
            chk($sformatf("v%0d_ready", k), 64'(wb_ready), 64'(tbl[k].rdy));
            chk($sformatf("v%0d_empty", k), 64'(empty), 64'(tbl[k].emp));
            chk($sformatf("v%0d_rw", k), 64'(reg_write), 64'(tbl[k].rw));
            chk($sformatf("v%0d_wreg", k), 64'(write_reg), 64'(tbl[k].wreg));
            chk($sformatf("v%0d_wdata", k), write_data, tbl[k].wd);
            chk($sformatf("v%0d_hit1", k), 64'(fwd_hit1), 64'(tbl[k].h1));
            chk($sformatf("v%0d_data1", k), fwd_data1, tbl[k].fd1);
            chk($sformatf("v%0d_hit2", k), 64'(fwd_hit2), 64'(tbl[k].h2));
            chk($sformatf("v%0d_data2", k), fwd_data2, tbl[k].fd2);
            chk($sformatf("v%0d_drop", k), 64'(dropped), 64'(tbl[k].drop));
            clock_edge();
        end

        // reset while entries are pending; reset cycle itself has stall released
        for (int k = 1; k <= 3; k++) begin
            drive(mk(0,1,5'(k),64'(k*11),1,0,0), 1'b1); clock_edge();
        end
        drive(mk(1,1,4,64'h44,0,1,0), 1'b1);
        chk("rst_cycle_rw", 64'(reg_write), 64'd0);
        clock_edge();
        drive(mk(0,0,0,0,0,1,2), 1'b1);
        chk("rst_after_empty", 64'(empty), 64'd1);
        chk("rst_after_rw", 64'(reg_write), 64'd0);
        chk("rst_after_hit1", 64'(fwd_hit1), 64'd0);
        clock_edge();
        for (int k = 0; k < 3; k++) begin
            drive(mk(0,0,0,0,0,1,2), 1'b1);
            chk("rst_stale_rw", 64'(reg_write), 64'd0);
            clock_edge();
        end

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            x.rst = ($urandom_range(0, 249) == 0);
            x.v   = ($urandom_range(0, 9) < 7);
            x.rg  = 5'($urandom_range(0, 8));
            if (x.rg == 5'd8) x.rg = 5'd31;
            x.d   = {$urandom(), $urandom()};
            x.st  = ($urandom_range(0, 9) < 4);
            x.f1  = 5'($urandom_range(0, 8));
            if (x.f1 == 5'd8) x.f1 = 5'd31;
            x.f2  = 5'($urandom_range(0, 7));
            drive(x, 1'b1);
            clock_edge();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
